rgb_pixel_fifo: RTL and testbench

// - Parametrised elastic buffer for RGB pixels (r/g/b channels, CH_W bits each).
// - Holds up to DEPTH pixels, with valid/ready handshake on both sides.
// - Sits between pixel producers and consumers to absorb back-pressure.
// - Successor to the fixed 8-bit single-register RGB stages: adds depth, width and flow control.

---
 rtl/rgb_pixel_fifo_pkg.sv | 42 ++++
 rtl/rgb_pixel_fifo_mem.sv | 35 +++
 rtl/rgb_pixel_fifo.sv | 120 ++++++++++++
 tb/tb_rgb_pixel_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pixel_fifo_pkg.sv
// rgb_pkg: shared types and helpers for the RGB pixel FIFO.
//   CH_W_DEFAULT   default bits per colour channel
//   CH_MAX         widest channel the pack/unpack helpers support
//   rgb8_t         packed {r, g, b} pixel with 8-bit channels
//   rgb_pack       concatenates r/g/b of width ch_w into {r, g, b}
//   rgb_unpack     extracts one channel (RGB_IDX_*) of width ch_w from {r, g, b}
package rgb_pkg;

  localparam int CH_W_DEFAULT = 8;
  localparam int CH_MAX       = 32;

  localparam int RGB_IDX_B = 0;
  localparam int RGB_IDX_G = 1;
  localparam int RGB_IDX_R = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  // Wide carrier so the helpers work for any channel width up to CH_MAX;
  // callers cast the result down to their own 3*CH_W width.
  typedef logic [3*CH_MAX-1:0] rgb_word_t;

  function automatic rgb_word_t rgb_mask(input int ch_w);
    return (rgb_word_t'(1) << ch_w) - rgb_word_t'(1);
  endfunction

  function automatic rgb_word_t rgb_pack(input rgb_word_t r, input rgb_word_t g,
                                         input rgb_word_t b, input int ch_w);
    rgb_word_t m;
    m = rgb_mask(ch_w);
    return ((r & m) << (2 * ch_w)) | ((g & m) << ch_w) | (b & m);
  endfunction

  function automatic rgb_word_t rgb_unpack(input rgb_word_t px, input int ch_w,
                                           input int idx);
    return (px >> (idx * ch_w)) & rgb_mask(ch_w);
  endfunction

endpackage

// File: rtl/rgb_pixel_fifo_mem.sv
// rgb_pixel_fifo_mem: DEPTH x WIDTH register array for the pixel FIFO.
//   clk    rising-edge clock
//   reset  asynchronous active-high; clears every entry to 0
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  combinational read data (mem[raddr])
module rgb_pixel_fifo_mem #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rgb_pixel_fifo.sv
// rgb_pixel_fifo: elastic buffer for RGB pixels with valid/ready on both sides.
// Optional feature: define RGB_PIXEL_FIFO_BYPASS_EN for a zero-latency path
// from input to output while the FIFO is empty.
//   clk                  rising-edge clock
//   reset                asynchronous active-high reset
//   clear                synchronous flush (beats push/pop in the same cycle)
//   in_valid/in_ready    producer handshake; in_r/g/b input pixel
//   out_valid/out_ready  consumer handshake; out_r/g/b output pixel (fall-through)
//   count                number of stored pixels
module rgb_pixel_fifo
  import rgb_pkg::*;
#(
  parameter int CH_W  = CH_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH_W-1:0]            in_r,
  input  logic [CH_W-1:0]            in_g,
  input  logic [CH_W-1:0]            in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH_W-1:0]            out_r,
  output logic [CH_W-1:0]            out_g,
  output logic [CH_W-1:0]            out_b,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = 3 * CH_W;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Pointers carry one extra wrap bit above the address bits.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          byp_take;
  logic [PW-1:0] wdata;
  logic [PW-1:0] rdata;
  logic [CH_W-1:0] mem_r;
  logic [CH_W-1:0] mem_g;
  logic [CH_W-1:0] mem_b;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count    = CW'(wr_ptr - rd_ptr);
  // Registered state only: a full FIFO never accepts in the cycle it pops.
  assign in_ready = !reset && !full;

  assign wdata = PW'(rgb_pack(rgb_word_t'(in_r), rgb_word_t'(in_g),
                              rgb_word_t'(in_b), CH_W));
  assign mem_r = CH_W'(rgb_unpack(rgb_word_t'(rdata), CH_W, RGB_IDX_R));
  assign mem_g = CH_W'(rgb_unpack(rgb_word_t'(rdata), CH_W, RGB_IDX_G));
  assign mem_b = CH_W'(rgb_unpack(rgb_word_t'(rdata), CH_W, RGB_IDX_B));

`ifdef RGB_PIXEL_FIFO_BYPASS_EN
  // Empty FIFO presents the incoming pixel directly; it is only stored
  // when the consumer does not take it this cycle.
  always_comb begin
    byp_take  = 1'b0;
    out_valid = !empty;
    out_r     = mem_r;
    out_g     = mem_g;
    out_b     = mem_b;
    if (empty && in_valid) begin
      out_valid = 1'b1;
      out_r     = in_r;
      out_g     = in_g;
      out_b     = in_b;
      byp_take  = out_ready;
    end
  end
`else
  always_comb begin
    byp_take  = 1'b0;
    out_valid = !empty;
    out_r     = mem_r;
    out_g     = mem_g;
    out_b     = mem_b;
  end
`endif

  assign push = in_valid && in_ready && !byp_take;
  assign pop  = !empty && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  rgb_pixel_fifo_mem #(
    .WIDTH (PW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push && !clear),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_rgb_pixel_fifo.sv
// tb_rgb_pixel_fifo: directed-vector bench for rgb_pixel_fifo (CH_W=8, DEPTH=4).
// Honours RGB_PIXEL_FIFO_BYPASS_EN when defined for the build.
module tb_rgb_pixel_fifo;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_r, in_g, in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_r, out_g, out_b;
  logic [2:0] count;

  int n_vec = 0;
  int n_bad = 0;

  logic        exp_v;
  logic [23:0] exp_px;
  int          exp_cnt;

  rgb_pixel_fifo #(.CH_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int c);
    logic [7:0] r, g, b;
    r = 8'(c * 3 + 1);
    g = 8'(c * 5 + 2);
    b = 8'(c * 7 + 3);
    return {r, g, b};
  endfunction

  task automatic set_in(input logic [23:0] p);
    {in_r, in_g, in_b} = p;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in(24'h0);

    // reset held
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    #10 reset = 1'b0;
    cyc;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_count", count, 0);
    chk("idle_out", {out_r, out_g, out_b}, 24'h0);

    // two pushes with consumer stalled, then drain in order
    in_valid = 1'b1; set_in({8'd11, 8'd22, 8'd33});
    #1;
`ifdef RGB_PIXEL_FIFO_BYPASS_EN
    chk("lat_out_valid", out_valid, 1);
`else
    chk("lat_out_valid", out_valid, 0);
`endif
    cyc;
    chk("p1_count", count, 1);
    chk("p1_out_valid", out_valid, 1);
    chk("p1_out", {out_r, out_g, out_b}, {8'd11, 8'd22, 8'd33});
    set_in({8'd44, 8'd55, 8'd66});
    cyc;
    in_valid = 1'b0;
    #1;
    chk("p2_count", count, 2);
    chk("p2_out", {out_r, out_g, out_b}, {8'd11, 8'd22, 8'd33});
    cyc;
    chk("stall_count", count, 2);
    chk("stall_out", {out_r, out_g, out_b}, {8'd11, 8'd22, 8'd33});
    out_ready = 1'b1;
    cyc;
    chk("pop1_out", {out_r, out_g, out_b}, {8'd44, 8'd55, 8'd66});
    chk("pop1_count", count, 1);
    cyc;
    chk("pop2_count", count, 0);
    chk("pop2_out_valid", out_valid, 0);
    out_ready = 1'b0;

    // fill to DEPTH, then push+pop while full: only the pop happens
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; set_in(pix(100 + i));
      cyc;
    end
    in_valid = 1'b0;
    #1;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_out", {out_r, out_g, out_b}, pix(100));
    in_valid = 1'b1; set_in(pix(200)); out_ready = 1'b1;
    cyc;
    in_valid = 1'b0;
    #1;
    chk("fullpp_count", count, 3);
    chk("fullpp_in_ready", in_ready, 1);
    chk("fullpp_out", {out_r, out_g, out_b}, pix(101));
    cyc;
    chk("drain_a", {out_r, out_g, out_b}, pix(102));
    chk("drain_a_cnt", count, 2);
    cyc;
    chk("drain_b", {out_r, out_g, out_b}, pix(103));
    chk("drain_b_cnt", count, 1);
    cyc;
    chk("drain_end_cnt", count, 0);
    chk("drain_end_v", out_valid, 0);
    out_ready = 1'b0;

    // streaming: 20 pixels, one per cycle, pointers wrap
    for (int c = 0; c < 22; c++) begin
      if (c < 20) begin
        in_valid = 1'b1; set_in(pix(c));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      #1;
`ifdef RGB_PIXEL_FIFO_BYPASS_EN
      exp_v = (c < 20); exp_px = pix(c); exp_cnt = 0;
`else
      exp_v = (c >= 1 && c <= 20); exp_px = pix(c - 1); exp_cnt = exp_v ? 1 : 0;
`endif
      chk("strm_v", out_valid, exp_v);
      if (exp_v) chk("strm_px", {out_r, out_g, out_b}, exp_px);
      chk("strm_cnt", count, exp_cnt);
      if (c < 20) chk("strm_rdy", in_ready, 1);
      cyc;
    end
    out_ready = 1'b0;

    // clear beats a concurrent push
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; set_in(pix(300 + i));
      cyc;
    end
    in_valid = 1'b0;
    #1;
    chk("clr_pre_count", count, 3);
    clear = 1'b1; in_valid = 1'b1; set_in(pix(303));
    cyc;
    clear = 1'b0; in_valid = 1'b0;
    #1;
    chk("clr_count", count, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    in_valid = 1'b1; set_in(pix(304));
    cyc;
    in_valid = 1'b0;
    #1;
    chk("clr_after_count", count, 1);
    chk("clr_after_out", {out_r, out_g, out_b}, pix(304));
    out_ready = 1'b1;
    cyc;
    out_ready = 1'b0;
    chk("clr_after_drain", count, 0);

    // asynchronous reset between edges
    in_valid = 1'b1; set_in(pix(400));
    cyc;
    set_in(pix(401));
    cyc;
    in_valid = 1'b0;
    #1;
    chk("arst_pre_count", count, 2);
    #1 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out", {out_r, out_g, out_b}, 24'h0);
    #2 reset = 1'b0;
    cyc;
    chk("arst_rel_in_ready", in_ready, 1);
    chk("arst_rel_count", count, 0);
    chk("arst_rel_out_valid", out_valid, 0);

`ifdef RGB_PIXEL_FIFO_BYPASS_EN
    // zero-latency pass-through when empty
    in_valid = 1'b1; out_ready = 1'b1; set_in(pix(500));
    #1;
    chk("byp_out_valid", out_valid, 1);
    chk("byp_out", {out_r, out_g, out_b}, pix(500));
    chk("byp_count", count, 0);
    cyc;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("byp_after_count", count, 0);
    chk("byp_after_valid", out_valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
